// File: rtl/rcb_pkg.sv
// Shared types, default geometry and the byte-merge helper for the RCB
// parameter RAM write path.
package rcb_pkg;

    localparam int RCB_DEF_WIDTH = 64;
    localparam int RCB_DEF_DEPTH = 512;
    // The merge helper works on the widest supported word; callers size in/out.
    localparam int RCB_MAX_WIDTH = 1024;
    localparam int RCB_MAX_BE    = RCB_MAX_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } rcb_wr_state_t;

    function automatic logic [RCB_MAX_WIDTH-1:0] rcb_be_merge(
        input logic [RCB_MAX_WIDTH-1:0] old_word,
        input logic [RCB_MAX_WIDTH-1:0] new_word,
        input logic [RCB_MAX_BE-1:0]    en
    );
        logic [RCB_MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < RCB_MAX_BE; i++) begin
            if (en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rcb_ram_sp.sv
// Single-port synchronous RAM, one access per cycle, 1-cycle read latency.
// Accesses beyond DEPTH (non-power-of-2 depths) are ignored.
module rcb_ram_sp #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;
    logic             in_range_s;

    generate
        if ((1 << AW) == DEPTH) begin : g_pow2
            assign in_range_s = 1'b1;
        end else begin : g_npow2
            assign in_range_s = (addr < AW'(DEPTH));
        end
    endgenerate

    // Storage and read register; a write cycle leaves the read register untouched.
    always_ff @(posedge clk) begin
        if (en && in_range_s) begin
            if (we) begin
                mem_r[addr] <= wdata;
            end else begin
                rdata_r <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/rcb_wr_resp.sv
// HPB write responder for the RCB parameter RAM: byte-enable writes with
// read-modify-write, sharing the single RAM port with priority lookup reads.
module rcb_wr_resp
    import rcb_pkg::*;
#(
    parameter int RCB_RAM_WIDTH = RCB_DEF_WIDTH,
    parameter int RCB_RAM_DEPTH = RCB_DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             hpb_wr_req,
    input  logic [$clog2(RCB_RAM_DEPTH)-1:0] hpb_wr_addr,
    input  logic [RCB_RAM_WIDTH-1:0]         hpb_wr_data,
    input  logic [RCB_RAM_WIDTH/8-1:0]       hpb_wr_en,
    output logic                             rcb_wr_done,
    output logic                             rcb_wr_busy,
    input  logic                             lk_rd_en,
    input  logic [$clog2(RCB_RAM_DEPTH)-1:0] lk_rd_addr,
    output logic [RCB_RAM_WIDTH-1:0]         lk_rd_data,
    output logic                             lk_rd_valid
);

    localparam int ADDR_W = $clog2(RCB_RAM_DEPTH);
    localparam int BE_W   = RCB_RAM_WIDTH / 8;

    rcb_wr_state_t            state_r, state_s;
    logic [ADDR_W-1:0]        addr_r;
    logic [RCB_RAM_WIDTH-1:0] data_r;
    logic [BE_W-1:0]          en_r;
    logic [RCB_RAM_WIDTH-1:0] buf_r, buf_s;
    logic                     latch_s;
    logic                     done_r, busy_r;
    logic                     lk_valid_r;
    logic [RCB_RAM_WIDTH-1:0] lk_hold_r;
    logic                     ram_en_s, ram_we_s;
    logic [ADDR_W-1:0]        ram_addr_s;
    logic [RCB_RAM_WIDTH-1:0] ram_q_s, merged_s;

    assign merged_s = RCB_RAM_WIDTH'(rcb_be_merge(RCB_MAX_WIDTH'(ram_q_s),
                                                  RCB_MAX_WIDTH'(data_r),
                                                  RCB_MAX_BE'(en_r)));

    // RAM port arbitration: a lookup strobe always wins the cycle.
    always_comb begin
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = addr_r;
        if (lk_rd_en) begin
            ram_en_s   = 1'b1;
            ram_addr_s = lk_rd_addr;
        end else if (state_r == ST_RD) begin
            ram_en_s = 1'b1;
        end else if (state_r == ST_WR) begin
            ram_en_s = 1'b1;
            ram_we_s = 1'b1;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // Write FSM next state, merge buffer and request capture.
    always_comb begin
        state_s = state_r;
        buf_s   = buf_r;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hpb_wr_req) begin
                    latch_s = 1'b1;
                    if (hpb_wr_en == {BE_W{1'b1}}) begin
                        buf_s   = hpb_wr_data;
                        state_s = ST_WR;
                    end else if (hpb_wr_en == {BE_W{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (lk_rd_en) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                buf_s   = merged_s;
                state_s = ST_WR;
            end
            ST_WR: begin
                if (lk_rd_en) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // Holding req high here never restarts the write.
                if (hpb_wr_req) begin
                    state_s = ST_WAIT_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request, registered handshake and lookup outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            data_r     <= {RCB_RAM_WIDTH{1'b0}};
            en_r       <= {BE_W{1'b0}};
            buf_r      <= {RCB_RAM_WIDTH{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            lk_valid_r <= 1'b0;
            lk_hold_r  <= {RCB_RAM_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            buf_r      <= buf_s;
            done_r     <= (state_s == ST_DONE);
            busy_r     <= (state_s != ST_IDLE);
            lk_valid_r <= lk_rd_en;
            if (latch_s) begin
                addr_r <= hpb_wr_addr;
                data_r <= hpb_wr_data;
                en_r   <= hpb_wr_en;
            end
            if (lk_valid_r) begin
                lk_hold_r <= ram_q_s;
            end
        end
    end

    rcb_ram_sp #(
        .WIDTH (RCB_RAM_WIDTH),
        .DEPTH (RCB_RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (buf_r),
        .rdata (ram_q_s)
    );

    // RMW reads also move the RAM output, so lookup data is held outside valid cycles.
    assign lk_rd_data  = lk_valid_r ? ram_q_s : lk_hold_r;
    assign lk_rd_valid = lk_valid_r;
    assign rcb_wr_done = done_r;
    assign rcb_wr_busy = busy_r;

endmodule

// File: tb/tb_rcb_wr_resp.sv
// Randomized bench for rcb_wr_resp against a word-level model of the parameter
// RAM, with directed write/contention/handshake/reset scenarios up front.
module tb_rcb_wr_resp;

    localparam int W  = 64;
    localparam int D  = 500;
    localparam int AW = 9;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hpb_wr_req;
    logic [AW-1:0] hpb_wr_addr;
    logic [W-1:0]  hpb_wr_data;
    logic [BW-1:0] hpb_wr_en;
    logic          rcb_wr_done;
    logic          rcb_wr_busy;
    logic          lk_rd_en;
    logic [AW-1:0] lk_rd_addr;
    logic [W-1:0]  lk_rd_data;
    logic          lk_rd_valid;

    always #5 clk = ~clk;

    rcb_wr_resp #(.RCB_RAM_WIDTH(W), .RCB_RAM_DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hpb_wr_req  (hpb_wr_req),
        .hpb_wr_addr (hpb_wr_addr),
        .hpb_wr_data (hpb_wr_data),
        .hpb_wr_en   (hpb_wr_en),
        .rcb_wr_done (rcb_wr_done),
        .rcb_wr_busy (rcb_wr_busy),
        .lk_rd_en    (lk_rd_en),
        .lk_rd_addr  (lk_rd_addr),
        .lk_rd_data  (lk_rd_data),
        .lk_rd_valid (lk_rd_valid)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [BW-1:0] en;
        int            hold;
        int            gap;
        int            pct;
        int            f_lo;
        int            f_hi;
    } item_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] mem_m [8];
    item_t        items[$];
    logic         pend;
    logic [W-1:0] pend_exp;
    logic [W-1:0] last_lk;
    logic [63:0]  hist;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                           input logic [BW-1:0] e);
        logic [W-1:0] r;
        r = o;
        for (int b = 0; b < BW; b++) begin
            if (e[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    // Done cycle from port usage: the read needs a free cycle from 1, the write a
    // free cycle at least two after the read (or from 1 for full writes).
    function automatic int exp_done(input logic [BW-1:0] en, input logic [63:0] h);
        int c;
        if (en == 8'h00) return 1;
        c = 1;
        if (en != 8'hFF) begin
            while (c < 60 && h[c]) c++;
            c = c + 2;
        end
        while (c < 60 && h[c]) c++;
        return c + 1;
    endfunction

    function automatic item_t mk(input logic [AW-1:0] a, input logic [W-1:0] d,
                                 input logic [BW-1:0] e, input int hold, input int gap,
                                 input int pct, input int lo, input int hi);
        item_t it;
        it.addr = a; it.data = d; it.en = e; it.hold = hold; it.gap = gap;
        it.pct = pct; it.f_lo = lo; it.f_hi = hi;
        return it;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (pend) begin
            check("lk_valid", lk_rd_valid, 1'b1);
            check("lk_data", lk_rd_data, pend_exp);
            last_lk = pend_exp;
        end else begin
            check("lk_valid_low", lk_rd_valid, 1'b0);
            check("lk_data_hold", lk_rd_data, last_lk);
        end
        pend     = 1'b0;
        lk_rd_en = 1'b0;
    endtask

    task automatic lk(input logic [AW-1:0] a);
        lk_rd_en   = 1'b1;
        lk_rd_addr = a;
        pend       = 1'b1;
        pend_exp   = mem_m[a[2:0]];
    endtask

    task automatic commit(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [BW-1:0] e);
        if (a < 8) mem_m[a[2:0]] = merge(mem_m[a[2:0]], d, e);
    endtask

    task automatic run_item(input item_t it);
        int phase;
        int hold_left;
        for (int g = 0; g <= it.gap; g++) begin
            tick();
            check("busy_idle", rcb_wr_busy, 1'b0);
            check("done_idle", rcb_wr_done, 1'b0);
            if (g < it.gap && $urandom_range(99) < it.pct) lk(AW'($urandom_range(7)));
        end
        hpb_wr_req  = 1'b1;
        hpb_wr_addr = it.addr;
        hpb_wr_data = it.data;
        hpb_wr_en   = it.en;
        hist        = 64'd0;
        if ((it.f_lo == 0) || ($urandom_range(99) < it.pct)) begin
            lk(AW'($urandom_range(7)));
            hist[0] = 1'b1;
        end
        phase     = 1;
        hold_left = it.hold;
        for (int cyc = 1; cyc < 100 && phase != 0; cyc++) begin
            tick();
            check("busy_active", rcb_wr_busy, 1'b1);
            if (phase == 1) begin
                if (rcb_wr_done) begin
                    check("done_cycle", 64'(cyc), 64'(exp_done(it.en, hist)));
                    commit(it.addr, it.data, it.en);
                    phase = 2;
                end
            end else begin
                check("done_once", rcb_wr_done, 1'b0);
                if (hold_left == 0) begin
                    hpb_wr_req = 1'b0;
                    phase      = 0;
                end else begin
                    hold_left--;
                end
            end
            hpb_wr_addr = AW'($urandom_range(511));
            hpb_wr_data = rnd64();
            hpb_wr_en   = BW'($urandom_range(255));
            if (cyc >= it.f_lo && cyc <= it.f_hi) begin
                lk(it.addr);
                if (cyc < 64) hist[cyc] = 1'b1;
            end else if ($urandom_range(99) < it.pct) begin
                lk(AW'($urandom_range(7)));
                if (cyc < 64) hist[cyc] = 1'b1;
            end
        end
        if (phase != 0) begin
            check("done_timeout", 64'(phase), 64'd0);
            hpb_wr_req = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] e;
        logic [AW-1:0] a;
        int            cnt;
        reset_n     = 1'b0;
        hpb_wr_req  = 1'b0;
        hpb_wr_addr = '0;
        hpb_wr_data = '0;
        hpb_wr_en   = '0;
        lk_rd_en    = 1'b0;
        lk_rd_addr  = '0;
        pend        = 1'b0;
        pend_exp    = '0;
        last_lk     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", rcb_wr_done, 1'b0);
        check("rst_busy", rcb_wr_busy, 1'b0);
        check("rst_valid", lk_rd_valid, 1'b0);
        check("rst_lk_data", lk_rd_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) items.push_back(mk(AW'(i), rnd64(), 8'hFF, 0, 0, 0, 99, 0));
        items.push_back(mk(9'd5, 64'h1122334455667788, 8'hFF, 0, 1, 0, 3, 3));
        items.push_back(mk(9'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 1, 0, 5, 5));
        items.push_back(mk(9'd5, rnd64(), 8'h3C, 0, 1, 0, 1, 6));
        items.push_back(mk(9'd5, rnd64(), 8'h00, 0, 1, 0, 2, 2));
        items.push_back(mk(9'd5, rnd64(), 8'hFF, 10, 1, 0, 6, 6));
        items.push_back(mk(9'd5, rnd64(), 8'h5A, 0, 0, 0, 5, 5));
        items.push_back(mk(9'd505, rnd64(), 8'hFF, 0, 1, 0, 99, 0));
        items.push_back(mk(9'd507, rnd64(), 8'h81, 1, 1, 0, 99, 0));
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(7))
                0, 1:    e = 8'hFF;
                2:       e = 8'h00;
                default: e = BW'($urandom_range(255));
            endcase
            a = ($urandom_range(9) == 0) ? AW'(500 + $urandom_range(11)) : AW'($urandom_range(7));
            items.push_back(mk(a, rnd64(), e, $urandom_range(3), $urandom_range(2), 30, 99, 0));
        end
        foreach (items[i]) run_item(items[i]);

        // Reset while the RMW read result is being merged: the write must be lost.
        tick();
        hpb_wr_req  = 1'b1;
        hpb_wr_addr = 9'd3;
        hpb_wr_data = ~mem_m[3];
        hpb_wr_en   = 8'hF0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_done", rcb_wr_done, 1'b0);
        check("mid_rst_busy", rcb_wr_busy, 1'b0);
        check("mid_rst_valid", lk_rd_valid, 1'b0);
        check("mid_rst_lk_data", lk_rd_data, 64'd0);
        last_lk    = '0;
        hpb_wr_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_done", rcb_wr_done, 1'b0);
            check("post_rst_busy", rcb_wr_busy, 1'b0);
            if (i == 3) lk(9'd3);
        end
        tick();
        hpb_wr_req  = 1'b1;
        hpb_wr_addr = 9'd3;
        hpb_wr_data = rnd64();
        hpb_wr_en   = 8'hFF;
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (rcb_wr_done) begin
                cnt = c;
                break;
            end
        end
        check("post_rst_write_cycle", 64'(cnt), 64'd2);
        commit(9'd3, hpb_wr_data, 8'hFF);
        tick();
        hpb_wr_req = 1'b0;
        tick();
        lk(9'd3);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rcb_wr_resp.md
Name: rcb_wr_resp

Overview:
- Responder end of the host parameter-bus (HPB) write channel into the RCB parameter RAM used by the strategy block.
- Accepts one host write request at a time, with per-byte enables. Performs a read-modify-write into a single-port RAM when needed.
- Shares that RAM port with the strategy lookup read path. Lookup always has priority.
- Signals completion to the host with a one-cycle rcb_wr_done pulse.

Parameters:
- RCB_RAM_WIDTH, 64, RAM word width in bits; must be a multiple of 8.
- RCB_RAM_DEPTH, 512, number of RAM words.
- Derived localparam ADDR_W = $clog2(RCB_RAM_DEPTH).
- Derived localparam BE_W = RCB_RAM_WIDTH/8.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- hpb_wr_req  in  1  host write request; level, held until rcb_wr_done is seen.
- hpb_wr_addr  in  ADDR_W  word address; stable while req is high.
- hpb_wr_data  in  RCB_RAM_WIDTH  write data; stable while req is high.
- hpb_wr_en  in  BE_W  byte enables; bit i covers data[8i+7:8i].
- rcb_wr_done  out  1  one-cycle completion pulse.
- rcb_wr_busy  out  1  high from request acceptance until return to IDLE.
- lk_rd_en  in  1  strategy lookup read strobe.
- lk_rd_addr  in  ADDR_W  lookup address.
- lk_rd_data  out  RCB_RAM_WIDTH  lookup data.
- lk_rd_valid  out  1  lookup data valid, exactly 1 cycle after lk_rd_en.

Behaviour:
- Reset values: rcb_wr_done=0, rcb_wr_busy=0, lk_rd_valid=0, lk_rd_data=0, FSM=IDLE, merge buffer=0. RAM contents are not reset.
- RAM: single port, synchronous, 1-cycle read latency. One access per cycle: read or write.
- Port arbitration: lk_rd_en=1 always owns the port that cycle.
- Lookup reads: lk_rd_valid=1 one cycle after lk_rd_en, independent of FSM state. lk_rd_data holds its last value otherwise.
- FSM states: IDLE, RD, RD_WAIT, WR, DONE, WAIT_LOW.
- IDLE, on hpb_wr_req=1 (cycle 0): latch addr, data and en. Set busy.
  - en all ones -> load buffer with data, go to WR.
  - en all zeros -> go to DONE; no RAM access.
  - otherwise -> go to RD.
- RD: issue RAM read of latched addr if lk_rd_en=0, then go to RD_WAIT. Otherwise stay in RD (stall).
- RD_WAIT: form buffer = per byte (en[i] ? wdata byte : ram byte), then go to WR. Lookup use of the port this cycle is legal.
- WR: write buffer to latched addr if lk_rd_en=0, then go to DONE. Otherwise stay in WR; buffer is held.
- DONE: rcb_wr_done=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: busy stays 1 while hpb_wr_req=1. Go to IDLE once req=0; busy=0 from that IDLE cycle.
  - A req held high after done never causes a second write.
- Unstalled latency, req sampled in cycle 0:
  - full-BE: done in cycle 2.
  - partial: done in cycle 4.
  - zero-BE: done in cycle 1.
- Stalls add exactly one cycle per lk_rd_en cycle spent in RD or WR.
- Lookup to the address under RMW, between RD and WR, returns pre-write data. Lookup in the cycle after the write returns new data.
- Host inputs changing while busy are ignored; only latched copies are used.
- Address >= RCB_RAM_DEPTH (non-power-of-2 depth): write dropped, done still pulsed.
- Reset mid-operation: FSM returns to IDLE immediately. No pending write occurs after reset release. No done is pulsed for the aborted request.

Decomposition:
- Package rcb_pkg holds:
  - the FSM state enum rcb_wr_state_t.
  - the byte-merge function rcb_be_merge(old, new, en).
  - default width/depth constants shared with the strategy block.
- One sub-module: rcb_ram_sp, a parameterised single-port RAM with 1-cycle read latency, instantiated once.

Test Plan:
- Full-BE write: req with addr=5, data=64'h1122334455667788, en=8'hFF in cycle 0 -> done in cycle 2. Then lk_rd_addr=5 -> lk_rd_data=64'h1122334455667788 one cycle later.
- Partial write: after the previous test, addr=5, data=64'hAAAAAAAAAAAAAAAA, en=8'h0F -> done in cycle 4. Lookup then returns 64'h11223344AAAAAAAA.
- Lookup contention: partial write with lk_rd_en held high for 6 cycles starting in the RD cycle -> done delayed by exactly 6 cycles. Final word is correct, and all 6 lookups return valid data 1 cycle after each strobe.
- Zero-BE: en=0, addr=5 -> done in cycle 1. Word 5 is unchanged and no RAM write strobe is seen.
- Handshake: req held high 10 cycles past done -> exactly one write and busy=1 throughout. Drop req and re-raise with new data -> a second done and the new data written.
- Reset mid-RMW: assert reset_n=0 while in RD_WAIT -> done=0 and busy=0 immediately. After release, word unchanged and FSM in IDLE.
